// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch stage
// Rev 1.0   : initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INST_W   = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : DEPTH-entry instruction buffer with push/pop/flush and count
// Rev 1.0    : initial release
// ============================================================================
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : pipelined in-order instruction fetch with redirect and buffering
//              Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN
// Rev 1.0    : initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [XLEN-1:0]   if_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_fault
);

  localparam int            CW        = $clog2(DEPTH + 1);
  localparam int            EW        = XLEN + INST_W;
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;
  logic            fifo_push, fifo_empty, credit_ok;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect_misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt        = redirect_pc;
  assign redirect_misaligned = |redirect_pc[1:0];
  assign if_fault            = (state_q == ST_FAULT);
`else
  logic unused_align;
  assign unused_align        = ^redirect_pc[1:0];
  assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign redirect_misaligned = 1'b0;
  assign if_fault            = 1'b0;
`endif

  // Buffered plus in-flight entries never exceed DEPTH, so a response always has a slot.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_LIM;
  assign imem_req  = !rst && !redirect_valid && (state_q == ST_RUN) && credit_ok;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_push     = 1'b0;
    outstanding_d = outstanding_q + CW'(imem_req) - CW'(imem_rvalid);
    if (imem_req) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (imem_rvalid) begin
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else if (state_q == ST_RUN) begin
        fifo_push = 1'b1;
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
    end
    // Everything still owed by memory after this cycle belongs to the old path.
    if (redirect_valid) begin
      fifo_push  = 1'b0;
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
      state_d    = redirect_misaligned ? ST_FAULT : ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({resp_pc_q, imem_rdata}),
    .pop       (if_valid && if_ready),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign if_valid = !fifo_empty && !redirect_valid;
  assign if_inst  = fifo_head[INST_W-1:0];
  assign if_pc    = fifo_head[EW-1:INST_W];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : randomized self-checking bench with a queue-based memory and
//                 an in-order PC stream model of the fetch stage
// Rev 1.0       : initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_rvalid, if_valid, if_ready, redirect_valid, if_fault;
  logic [31:0] imem_addr, imem_rdata, if_inst, if_pc, redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_fault(if_fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ a ^ 32'h1357_9BDF;
  endfunction

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       memq[$];
  int          cyc, last_due, lat_min, lat_max;
  logic [31:0] exp_pc, exp_req;
  logic        m_fault;
  logic        drv_ready, drv_redir;
  logic [31:0] drv_tgt;
  logic        o_req, o_pop, o_valid;
  logic [31:0] o_addr, o_pc;

  // One clock cycle: drive, settle, compare against the stream model, advance.
  task automatic step();
    logic rv;
    int   due;
    rv             = (memq.size() > 0) && (memq[0].due == cyc);
    imem_rvalid    = rv;
    imem_rdata     = rv ? inst_of(memq[0].addr) : 32'h0;
    if_ready       = drv_ready;
    redirect_valid = drv_redir;
    redirect_pc    = drv_tgt;
    #2;
    o_req = imem_req; o_addr = imem_addr; o_valid = if_valid;
    o_pop = if_valid && if_ready; o_pc = if_pc;
    check_eq("if_fault", if_fault, m_fault);
    if (rv) void'(memq.pop_front());
    if (m_fault) begin
      check_eq("fault_no_req", imem_req, 0);
      check_eq("fault_no_valid", if_valid, 0);
    end
    if (imem_req) begin
      check_eq("req_addr", imem_addr, exp_req);
      exp_req = exp_req + 32'd4;
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back(mreq_t'{addr: imem_addr, due: due});
      check_eq("inflight_le_depth", memq.size() <= DEPTH, 1);
    end
    if (drv_redir) begin
      check_eq("redir_no_valid", if_valid, 0);
      check_eq("redir_no_req", imem_req, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault = (drv_tgt[1:0] != 2'b00);
      exp_pc  = drv_tgt;
      exp_req = drv_tgt;
`else
      exp_pc  = {drv_tgt[31:2], 2'b00};
      exp_req = {drv_tgt[31:2], 2'b00};
`endif
    end else if (if_valid && if_ready) begin
      check_eq("if_pc", if_pc, exp_pc);
      check_eq("if_inst", if_inst, inst_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    memq.delete();
    last_due = -1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", if_valid, 0);
    check_eq("rst_inst", if_inst, 0);
    check_eq("rst_pc", if_pc, 0);
    check_eq("rst_fault", if_fault, 0);
    rst = 1'b0;
    cyc = 0; exp_pc = RST_PC; exp_req = RST_PC; m_fault = 1'b0;
    drv_ready = 1'b1; drv_redir = 1'b0; drv_tgt = '0;
  endtask

  // Step until the next handshake (bounded); returns its cycle or -1.
  task automatic run_to_pop(input int budget, output int at);
    int c;
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      c = cyc;
      step();
      if (o_pop) at = c;
    end
    check_eq("pop_within_budget", at >= 0, 1);
  endtask

  initial begin
    int first, npop, nreq, at, n;
    logic [31:0] reqs[$];

    // Reset PC, 1-cycle memory, decode always ready
    lat_min = 1; lat_max = 1;
    do_reset();
    first = -1; npop = 0;
    for (int i = 0; i < 12; i++) begin
      n = cyc;
      step();
      if (n == 0) begin
        check_eq("t1_first_req", o_req, 1);
        check_eq("t1_first_addr", o_addr, RST_PC);
      end
      if (o_pop) begin
        if (first < 0) first = n;
        npop++;
      end
    end
    check_eq("t1_first_valid_cycle", first, 2);
    check_eq("t1_throughput", npop, 10);

    // Decode stalled: credit limits requests to DEPTH, then drains in order
    do_reset();
    drv_ready = 1'b0; nreq = 0;
    for (int i = 0; i < 20; i++) begin step(); if (o_req) nreq++; end
    check_eq("t2_stall_reqs", nreq, DEPTH);
    drv_ready = 1'b1; npop = 0; nreq = 0;
    for (int i = 0; i < 4; i++) begin step(); if (o_pop) npop++; end
    check_eq("t2_drain", npop, 4);
    for (int i = 0; i < 6; i++) begin step(); if (o_req) nreq++; end
    check_eq("t2_resume", nreq > 0, 1);

    // 3-cycle memory, redirect with three fetches in flight
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (3) step();
    check_eq("t3_inflight", memq.size(), 3);
    drv_redir = 1'b1; drv_tgt = 32'h200; n = cyc; step(); drv_redir = 1'b0;
    step();
    check_eq("t3_req_tgt", o_addr, 32'h200);
    run_to_pop(20, at);
    check_eq("t3_first_pc", o_pc, 32'h200);
    check_eq("t3_latency", at >= n + 3, 1);

    // Redirect coinciding with a response arrival and a pop
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (5) step();
    drv_redir = 1'b1; drv_tgt = 32'h200; n = cyc; step(); drv_redir = 1'b0;
    step();
    check_eq("t4_flushed", o_valid, 0);
    run_to_pop(20, at);
    check_eq("t4_first_pc", o_pc, 32'h200);
    check_eq("t4_latency", at >= n + 3, 1);

    // Misaligned redirect target
    lat_min = 2; lat_max = 2;
    do_reset();
    repeat (6) step();
    drv_redir = 1'b1; drv_tgt = 32'h202; step(); drv_redir = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("t5_fault_set", if_fault, 1);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin step(); if (o_req) nreq++; end
    check_eq("t5_fault_no_req", nreq, 0);
    drv_redir = 1'b1; drv_tgt = 32'h300; step(); drv_redir = 1'b0;
    check_eq("t5_fault_clr", if_fault, 0);
    step();
    check_eq("t5_req_300", o_addr, 32'h300);
    run_to_pop(20, at);
    check_eq("t5_pc_300", o_pc, 32'h300);
`else
    step();
    check_eq("t5_req_aligned", o_addr, 32'h200);
    run_to_pop(20, at);
    check_eq("t5_pc_aligned", o_pc, 32'h200);
`endif

    // PC wrap at the top of the address space, then reset mid-burst
    lat_min = 1; lat_max = 1;
    drv_redir = 1'b1; drv_tgt = 32'hFFFF_FFF8; step(); drv_redir = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); if (o_req) reqs.push_back(o_addr); end
    check_eq("t6_nreq", reqs.size() >= 3, 1);
    check_eq("t6_req0", reqs.size() > 0 ? reqs[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    check_eq("t6_req1", reqs.size() > 1 ? reqs[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check_eq("t6_req2", reqs.size() > 2 ? reqs[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_async_req", imem_req, 0);
    check_eq("t6_async_valid", if_valid, 0);
    check_eq("t6_async_pc", if_pc, 0);
    check_eq("t6_async_inst", if_inst, 0);
    check_eq("t6_async_fault", if_fault, 0);
    do_reset();
    step();
    check_eq("t6_restart_addr", o_addr, RST_PC);

    // Randomized traffic: variable latency, backpressure, random redirects
    lat_min = 1; lat_max = 3;
    do_reset();
    npop = 0;
    for (int i = 0; i < 2000; i++) begin
      drv_ready = ($urandom_range(3, 0) != 0);
      drv_redir = ($urandom_range(31, 0) == 0);
      drv_tgt   = $urandom & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(5, 0) == 0) drv_tgt = drv_tgt | 32'($urandom_range(3, 1));
`endif
      step();
      if (o_pop) npop++;
    end
    drv_redir = 1'b0;
    check_eq("rand_progress", npop > 500, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
